// File: rtl/hazard_unit_mc.sv
// hazard_unit_mc: forwarding, load-use/branch hazard control and multi-cycle execute hold for a 5-stage RV32I core
module hazard_unit_mc #(
  parameter int REG_AW = 5,
  parameter int MC_LAT = 4,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] Rs1D,
  input  logic [REG_AW-1:0] Rs2D,
  input  logic [REG_AW-1:0] Rs1E,
  input  logic [REG_AW-1:0] Rs2E,
  input  logic [REG_AW-1:0] RdE,
  input  logic [REG_AW-1:0] RdM,
  input  logic [REG_AW-1:0] RdW,
  input  logic [1:0]        ResultSrcE,
  input  logic              RegWriteM,
  input  logic              RegWriteW,
  input  logic              PCSrcE,
  input  logic              MultiCycleE,
  output logic              StallF,
  output logic              StallD,
  output logic              StallE,
  output logic              FlushD,
  output logic              FlushE,
  output logic              FlushM,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              McBusy,
  output logic [PERF_W-1:0] StallCnt
);
  localparam int CW = $clog2(MC_LAT + 1);
  localparam logic MC_EN = MC_LAT > 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic lwStall, mcStall;
  // Operand forwarding (Memory beats Writeback), load-use detection and hazard outputs
  always_comb begin
    ForwardAE = (RegWriteM && Rs1E != '0 && Rs1E == RdM) ? 2'b10 :
                (RegWriteW && Rs1E != '0 && Rs1E == RdW) ? 2'b01 : 2'b00;
    ForwardBE = (RegWriteM && Rs2E != '0 && Rs2E == RdM) ? 2'b10 :
                (RegWriteW && Rs2E != '0 && Rs2E == RdW) ? 2'b01 : 2'b00;
    lwStall = (ResultSrcE == 2'b01) && (RdE != '0) && (Rs1D == RdE || Rs2D == RdE);
    mcStall = ~rst && ((state == IDLE && MultiCycleE && MC_EN) || (state == BUSY && cnt > CW'(1)));
    StallF = lwStall | mcStall;
    StallD = StallF;
    StallE = mcStall;
    FlushM = mcStall;
    FlushE = (lwStall | PCSrcE) & ~mcStall;
    FlushD = PCSrcE & ~mcStall;
  end
  // Multi-cycle hold: count down the remaining Execute cycles of the op
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      McBusy <= 1'b0;
    end else if (state == IDLE) begin
      if (MultiCycleE && MC_EN) begin
        state <= BUSY;
        cnt <= CW'(MC_LAT - 1);
        McBusy <= 1'b1;
      end
    end else if (cnt > CW'(1)) begin
      cnt <= cnt - CW'(1);
    end else begin
      state <= IDLE;
      cnt <= '0;
      McBusy <= 1'b0;
    end
  end
  // Saturating count of fetch-stall cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) StallCnt <= '0;
    else if (StallF && !(&StallCnt)) StallCnt <= StallCnt + PERF_W'(1);
  end
endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb_hazard_unit_mc: directed self-checking bench for hazard_unit_mc
module tb_hazard_unit_mc;
  logic clk = 0, rst = 1;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE;
  logic RegWriteM, RegWriteW, PCSrcE, MultiCycleE;
  logic stallF[3], stallD[3], stallE[3], flushD[3], flushE[3], flushM[3], mcBusy[3];
  logic [1:0] fwdA[3], fwdB[3];
  logic [31:0] cntMain, cnt1;
  logic [3:0] cnt4;
  int errCnt = 0, chkCnt = 0, expCnt = 0;
  logic [8:0] mceV, lwV, pcsV, stV, feV, busyV;

  always #5 clk = ~clk;

  hazard_unit_mc #(.REG_AW(5), .MC_LAT(4), .PERF_W(32)) dut (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MultiCycleE(MultiCycleE), .StallF(stallF[0]), .StallD(stallD[0]),
    .StallE(stallE[0]), .FlushD(flushD[0]), .FlushE(flushE[0]), .FlushM(flushM[0]),
    .ForwardAE(fwdA[0]), .ForwardBE(fwdB[0]), .McBusy(mcBusy[0]), .StallCnt(cntMain));

  hazard_unit_mc #(.REG_AW(5), .MC_LAT(1), .PERF_W(32)) dut1 (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MultiCycleE(MultiCycleE), .StallF(stallF[1]), .StallD(stallD[1]),
    .StallE(stallE[1]), .FlushD(flushD[1]), .FlushE(flushE[1]), .FlushM(flushM[1]),
    .ForwardAE(fwdA[1]), .ForwardBE(fwdB[1]), .McBusy(mcBusy[1]), .StallCnt(cnt1));

  hazard_unit_mc #(.REG_AW(5), .MC_LAT(4), .PERF_W(4)) dut4 (
    .clk(clk), .rst(rst), .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .PCSrcE(PCSrcE), .MultiCycleE(MultiCycleE), .StallF(stallF[2]), .StallD(stallD[2]),
    .StallE(stallE[2]), .FlushD(flushD[2]), .FlushE(flushE[2]), .FlushM(flushM[2]),
    .ForwardAE(fwdA[2]), .ForwardBE(fwdB[2]), .McBusy(mcBusy[2]), .StallCnt(cnt4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
    ResultSrcE = 2'b00;
    {RegWriteM, RegWriteW, PCSrcE, MultiCycleE} = '0;
  endtask

  task automatic setLw(input logic on);
    ResultSrcE = on ? 2'b01 : 2'b00;
    RdE = on ? 5'd7 : 5'd0;
    Rs2D = on ? 5'd7 : 5'd0;
  endtask

  initial begin
    idle();
    MultiCycleE = 1;
    #2;
    chk("rst_busy", mcBusy[0], 0);
    chk("rst_cnt", cntMain, 0);
    chk("rst_stallE", stallE[0], 0);
    chk("rst_flushM", flushM[0], 0);
    chk("rst_stallF", stallF[0], 0);
    MultiCycleE = 0;
    tick();
    rst = 0;
    #2;
    Rs1E = 5; Rs2E = 5; RdM = 5; RdW = 5; RegWriteM = 1; RegWriteW = 1;
    #1;
    chk("fwdA_mem", fwdA[0], 2'b10);
    chk("fwdB_mem", fwdB[0], 2'b10);
    RegWriteM = 0;
    #1;
    chk("fwdA_wb", fwdA[0], 2'b01);
    Rs1E = 0;
    #1;
    chk("fwdA_zero", fwdA[0], 2'b00);
    chk("fwdB_wb", fwdB[0], 2'b01);
    RegWriteW = 0;
    #1;
    chk("fwdB_none", fwdB[0], 2'b00);
    tick();
    idle();
    setLw(1);
    #2;
    chk("lw_stallF", stallF[0], 1);
    chk("lw_stallD", stallD[0], 1);
    chk("lw_flushE", flushE[0], 1);
    chk("lw_stallE", stallE[0], 0);
    tick();
    expCnt++;
    setLw(0);
    #2;
    chk("lw_cnt", cntMain, expCnt);
    chk("lw_release", stallF[0], 0);
    ResultSrcE = 2'b01; Rs2D = 0; RdE = 0;
    #2;
    chk("lw_rd0", stallF[0], 0);
    tick();
    chk("lw_rd0_cnt", cntMain, expCnt);
    idle();
    PCSrcE = 1;
    #2;
    chk("br_flushD", flushD[0], 1);
    chk("br_flushE", flushE[0], 1);
    chk("br_stallF", stallF[0], 0);
    tick();
    idle();
    MultiCycleE = 1;
    for (int i = 0; i < 4; i++) begin
      #2;
      chk($sformatf("mc_stallF%0d", i), stallF[0], i < 3);
      chk($sformatf("mc_stallD%0d", i), stallD[0], i < 3);
      chk($sformatf("mc_stallE%0d", i), stallE[0], i < 3);
      chk($sformatf("mc_flushM%0d", i), flushM[0], i < 3);
      chk($sformatf("mc_busy%0d", i), mcBusy[0], i >= 1);
      chk($sformatf("mc1_stallF%0d", i), stallF[1], 0);
      chk($sformatf("mc1_busy%0d", i), mcBusy[1], 0);
      tick();
      if (i < 3) expCnt++;
    end
    MultiCycleE = 0;
    #2;
    chk("mc_busy_end", mcBusy[0], 0);
    chk("mc_cnt", cntMain, expCnt);
    tick();
    mceV = 9'b011111111; lwV = 9'b101100000; pcsV = 9'b000010000;
    stV = 9'b101110111; feV = 9'b100000000; busyV = 9'b011101110;
    for (int i = 0; i < 9; i++) begin
      MultiCycleE = mceV[i];
      setLw(lwV[i]);
      PCSrcE = pcsV[i];
      #2;
      chk($sformatf("b2b_stallF%0d", i), stallF[0], stV[i]);
      chk($sformatf("b2b_flushE%0d", i), flushE[0], feV[i]);
      chk($sformatf("b2b_flushD%0d", i), flushD[0], 0);
      chk($sformatf("b2b_busy%0d", i), mcBusy[0], busyV[i]);
      chk($sformatf("b2b1_stallE%0d", i), stallE[1], 0);
      tick();
      if (stV[i]) expCnt++;
    end
    idle();
    #2;
    chk("b2b_cnt", cntMain, expCnt);
    chk("b2b_cnt4", cnt4, expCnt > 15 ? 15 : expCnt);
    MultiCycleE = 1;
    tick();
    tick();
    #1;
    chk("rstmid_pre_busy", mcBusy[0], 1);
    rst = 1;
    #1;
    expCnt = 0;
    chk("rstmid_busy", mcBusy[0], 0);
    chk("rstmid_cnt", cntMain, 0);
    chk("rstmid_cnt4", cnt4, 0);
    chk("rstmid_stallE", stallE[0], 0);
    chk("rstmid_flushM", flushM[0], 0);
    MultiCycleE = 0;
    tick();
    rst = 0;
    #2;
    chk("post_stallF", stallF[0], 0);
    tick();
    chk("post_busy", mcBusy[0], 0);
    chk("post_cnt", cntMain, 0);
    setLw(1);
    for (int i = 0; i < 18; i++) tick();
    expCnt += 18;
    setLw(0);
    #2;
    chk("sat_main", cntMain, expCnt);
    chk("sat_cnt4", cnt4, 15);
    setLw(1);
    tick();
    setLw(0);
    #2;
    chk("sat_hold", cnt4, 15);
    $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
    $finish;
  end
endmodule
